// File: rtl/kernel_bc_wb_pkg.sv
// Shared types and helpers for the write-back controller: FSM states,
// address scaling and {vertex_id, value} record field extraction.
package kernel_bc_wb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wb_state_e;

  // Records are widened to this container before slicing so one helper serves any width.
  localparam int REC_MAX_W = 512;

  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic [REC_MAX_W-1:0] rec_value(input logic [REC_MAX_W-1:0] rec,
                                                     input int data_width);
    return rec & ((REC_MAX_W'(1) << data_width) - REC_MAX_W'(1));
  endfunction

  function automatic logic [REC_MAX_W-1:0] rec_vid(input logic [REC_MAX_W-1:0] rec,
                                                   input int data_width);
    return rec >> data_width;
  endfunction

endpackage

// File: rtl/kernel_bc_write_back_ctrl_if.sv
// Bus bundle of the write-back controller: start-token FIFO, update FIFO,
// and the memory write request/response channel.
interface kernel_bc_write_back_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int VID_WIDTH  = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
);
  logic                          start_empty_n;
  logic                          start_read;
  logic                          start_dout;
  logic [CNT_WIDTH-1:0]          num_updates;
  logic [ADDR_WIDTH-1:0]         base_addr;
  logic                          upd_empty_n;
  logic                          upd_read;
  logic [VID_WIDTH+DATA_WIDTH-1:0] upd_dout;
  logic                          wr_req_valid;
  logic                          wr_req_ready;
  logic [ADDR_WIDTH-1:0]         wr_req_addr;
  logic [DATA_WIDTH-1:0]         wr_req_data;
  logic                          wr_rsp_valid;

  modport ctrl (
    input  start_empty_n, start_dout, num_updates, base_addr,
    input  upd_empty_n, upd_dout, wr_req_ready, wr_rsp_valid,
    output start_read, upd_read, wr_req_valid, wr_req_addr, wr_req_data
  );

  modport env (
    output start_empty_n, start_dout, num_updates, base_addr,
    output upd_empty_n, upd_dout, wr_req_ready, wr_rsp_valid,
    input  start_read, upd_read, wr_req_valid, wr_req_addr, wr_req_data
  );
endinterface

// File: rtl/kernel_bc_wb_outst_cnt.sv
// Outstanding write counter: +1 per accepted request, -1 per response,
// with a sticky error for a response that arrives when nothing is in flight.
module kernel_bc_wb_outst_cnt #(
  parameter  int MAX_OUTST = 16,
  localparam int CW        = $clog2(MAX_OUTST) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_full,
  output logic          o_zero,
  output logic          o_err
);
  logic [CW-1:0] r_cnt;
  logic          r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      unique case ({i_inc, i_dec})
        2'b10: r_cnt <= r_cnt + CW'(1);
        2'b01: begin
          if (r_cnt == '0) r_err <= 1'b1;
          else             r_cnt <= r_cnt - CW'(1);
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt  = r_cnt;
  assign o_full = (r_cnt == CW'(MAX_OUTST));
  assign o_zero = (r_cnt == '0);
  assign o_err  = r_err;

endmodule

// File: rtl/kernel_bc_write_back_ctrl.sv
// Write-back controller: per start token, drains num_updates records from the
// update FIFO into memory writes and waits for every write response.
module kernel_bc_write_back_ctrl
  import kernel_bc_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int VID_WIDTH  = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_OUTST  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  kernel_bc_write_back_ctrl_if.ctrl bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err_rsp
);
  localparam int SHIFT = byte_shift(DATA_WIDTH);
  localparam int OW    = $clog2(MAX_OUTST) + 1;

  wb_state_e             r_state, w_state_nxt;
  logic                  r_armed;
  logic [CNT_WIDTH-1:0]  r_cnt, r_processed;
  logic [ADDR_WIDTH-1:0] r_base, r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_data;
  logic                  r_req_valid;

  logic                  w_start_read, w_upd_read, w_accept;
  logic                  w_slot_free, w_outq_free, w_last;
  logic [OW-1:0]         w_outst_cnt;
  logic                  w_outst_full, w_outst_zero;
  logic [REC_MAX_W-1:0]  w_rec;
  logic [VID_WIDTH-1:0]  w_vid;
  logic [DATA_WIDTH-1:0] w_val;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_unused;

  assign w_unused = bus.start_dout;
  assign w_rec    = REC_MAX_W'(bus.upd_dout);
  assign w_vid    = VID_WIDTH'(rec_vid(w_rec, DATA_WIDTH));
  assign w_val    = DATA_WIDTH'(rec_value(w_rec, DATA_WIDTH));
  assign w_addr   = r_base + (ADDR_WIDTH'(w_vid) << SHIFT);

  // A request still sitting in the output register already claims a slot.
  assign w_accept    = r_req_valid & bus.wr_req_ready;
  assign w_outq_free = ~r_req_valid | bus.wr_req_ready;
  assign w_slot_free = ~w_outst_full & ~(r_req_valid & (w_outst_cnt == OW'(MAX_OUTST - 1)));
  assign w_last      = ((r_processed + CNT_WIDTH'(1)) == r_cnt);

  always_comb begin
    w_state_nxt  = r_state;
    w_start_read = 1'b0;
    w_upd_read   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_start_read = bus.start_empty_n & r_armed;
        if (w_start_read) w_state_nxt = (bus.num_updates == '0) ? DRAIN : RUN;
      end
      RUN: begin
        w_upd_read = bus.upd_empty_n & (r_processed < r_cnt) & w_slot_free & w_outq_free;
        if (w_upd_read && w_last) w_state_nxt = DRAIN;
      end
      DRAIN: if (!r_req_valid && w_outst_zero) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_armed keeps start_read low while reset is held and for the first cycle after it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_armed     <= 1'b0;
      r_cnt       <= '0;
      r_base      <= '0;
      r_processed <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
      if (w_start_read) begin
        r_cnt       <= bus.num_updates;
        r_base      <= bus.base_addr;
        r_processed <= '0;
      end
      if (w_upd_read) begin
        r_processed <= r_processed + CNT_WIDTH'(1);
        r_req_valid <= 1'b1;
        r_req_addr  <= w_addr;
        r_req_data  <= w_val;
      end else if (bus.wr_req_ready) begin
        r_req_valid <= 1'b0;
      end
    end
  end

  kernel_bc_wb_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_outst (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_accept),
    .i_dec   (bus.wr_rsp_valid),
    .o_cnt   (w_outst_cnt),
    .o_full  (w_outst_full),
    .o_zero  (w_outst_zero),
    .o_err   (err_rsp)
  );

  assign bus.start_read   = w_start_read;
  assign bus.upd_read     = w_upd_read;
  assign bus.wr_req_valid = r_req_valid;
  assign bus.wr_req_addr  = r_req_addr;
  assign bus.wr_req_data  = r_req_data;
  assign busy             = (r_state != IDLE);
  assign done             = (r_state == DONE);

endmodule

// File: tb/tb_kernel_bc_write_back_ctrl.sv
// Directed bench for kernel_bc_write_back_ctrl: FIFO and memory models run one
// cycle at a time from tick(); each test task checks its own expectations.
module tb_kernel_bc_write_back_ctrl;
  localparam int DW = 32, VW = 32, AW = 64, CW = 32, MO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy, done, err_rsp;

  kernel_bc_write_back_ctrl_if #(.DATA_WIDTH(DW), .VID_WIDTH(VW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  kernel_bc_write_back_ctrl #(.DATA_WIDTH(DW), .VID_WIDTH(VW), .ADDR_WIDTH(AW),
                              .CNT_WIDTH(CW), .MAX_OUTST(MO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy), .done(done), .err_rsp(err_rsp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  logic [VW+DW-1:0] upd_q[$];
  int               pend[$];
  logic [AW-1:0]    acc_addr[$];
  logic [DW-1:0]    acc_data[$];
  int  done_cnt = 0, done_cyc = 0, rsp_cnt = 0, last_rsp_cyc = 0;
  int  start_pops = 0, pop_cyc = 0, upd_pops = 0, stab_viol = 0;
  bit  prev_stall = 0, rsp_hold = 0, rdy_rand = 0;
  logic rdy_fixed = 1'b1;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic drive_upd();
    bus.upd_empty_n = (upd_q.size() != 0);
    bus.upd_dout    = (upd_q.size() != 0) ? upd_q[0] : '0;
  endtask

  task automatic push_rec(input logic [VW-1:0] vid, input logic [DW-1:0] val);
    upd_q.push_back({vid, val});
    drive_upd();
  endtask

  task automatic give_token(input logic [CW-1:0] n, input logic [AW-1:0] base);
    bus.num_updates   = n;
    bus.base_addr     = base;
    bus.start_empty_n = 1'b1;
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_data.delete();
    done_cnt = 0; rsp_cnt = 0; start_pops = 0; upd_pops = 0; stab_viol = 0;
  endtask

  // One clock: sample what the DUT presents to the edge, take the edge, update the models.
  task automatic tick();
    logic s_start, s_upd, s_v, s_r, s_rsp, s_done;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    #1;
    s_start = bus.start_read;   s_upd  = bus.upd_read;
    s_v     = bus.wr_req_valid; s_r    = bus.wr_req_ready;
    s_addr  = bus.wr_req_addr;  s_data = bus.wr_req_data;
    s_rsp   = bus.wr_rsp_valid; s_done = done;
    if (prev_stall && (!s_v || s_addr !== prev_addr || s_data !== prev_data)) stab_viol++;
    prev_stall = s_v & ~s_r; prev_addr = s_addr; prev_data = s_data;
    if (s_done)  begin done_cnt++; done_cyc = cyc; end
    if (s_rsp)   begin rsp_cnt++; last_rsp_cyc = cyc; end
    if (s_start) begin start_pops++; pop_cyc = cyc; end
    if (s_upd)   upd_pops++;
    if (s_v && s_r) begin
      acc_addr.push_back(s_addr); acc_data.push_back(s_data); pend.push_back(cyc + 2);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (s_start) begin
      bus.start_empty_n = 1'b0;
      bus.num_updates   = $urandom;
      bus.base_addr     = {$urandom, $urandom};
    end
    if (s_upd && upd_q.size() != 0) void'(upd_q.pop_front());
    drive_upd();
    bus.wr_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    if (!rsp_hold && pend.size() != 0 && pend[0] <= cyc) begin
      bus.wr_rsp_valid = 1'b1;
      void'(pend.pop_front());
    end else begin
      bus.wr_rsp_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.start_empty_n = 1'b1; bus.start_dout = 1'b1;
    bus.num_updates = 5; bus.base_addr = 64'h55;
    bus.upd_empty_n = 1'b1; bus.upd_dout = '1;
    bus.wr_req_ready = 1'b1; bus.wr_rsp_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    n_cmp++; if (bus.start_read !== 1'b0) begin n_fail++; $display("FAIL rst_start_read: got %b want 0", bus.start_read); end
    n_cmp++; if (bus.upd_read !== 1'b0) begin n_fail++; $display("FAIL rst_upd_read: got %b want 0", bus.upd_read); end
    for (int k = 0; k < 3; k++) tick();
    n_cmp++; if (bus.wr_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.wr_req_valid); end
    n_cmp++; if (bus.wr_req_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.wr_req_addr); end
    n_cmp++; if (bus.wr_req_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus.wr_req_data); end
    n_cmp++; if ({busy, done, err_rsp} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b want 000", {busy, done, err_rsp}); end
    n_cmp++; if (start_pops !== 0) begin n_fail++; $display("FAIL rst_no_pop: got %0d want 0", start_pops); end
    bus.start_empty_n = 1'b0;
    reset_n = 1'b1;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea[3];
    logic [DW-1:0] ed[3];
    ea = '{64'h1008, 64'h1014, 64'h1000};
    ed = '{32'hA, 32'hB, 32'hC};
    clear_logs();
    push_rec(2, 32'hA); push_rec(5, 32'hB); push_rec(0, 32'hC);
    give_token(3, 64'h1000);
    for (int k = 0; k < 100 && done_cnt == 0; k++) tick();
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt); end
    n_cmp++; if (acc_addr.size() !== 3) begin n_fail++; $display("FAIL basic_count: got %0d writes want 3", acc_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= acc_addr.size() || acc_addr[i] !== ea[i] || acc_data[i] !== ed[i]) begin
        n_fail++; $display("FAIL basic_write%0d: got %h/%h want %h/%h", i,
                           (i < acc_addr.size()) ? acc_addr[i] : 'x, (i < acc_data.size()) ? acc_data[i] : 'x, ea[i], ed[i]);
      end
    end
    n_cmp++; if (done_cyc !== last_rsp_cyc + 2) begin n_fail++; $display("FAIL basic_done_time: got cycle %0d want %0d", done_cyc, last_rsp_cyc + 2); end
    #1;
    n_cmp++; if ({done, busy, err_rsp} !== 3'b000) begin n_fail++; $display("FAIL basic_after: got %b want 000", {done, busy, err_rsp}); end
  endtask

  task automatic test_zero();
    clear_logs();
    push_rec(7, 32'h77);
    give_token(0, 64'h3000);
    for (int k = 0; k < 50 && done_cnt == 0; k++) tick();
    n_cmp++; if (start_pops !== 1) begin n_fail++; $display("FAIL zero_pop: got %0d want 1", start_pops); end
    n_cmp++; if (upd_pops !== 0) begin n_fail++; $display("FAIL zero_upd_read: got %0d want 0", upd_pops); end
    n_cmp++; if (acc_addr.size() !== 0) begin n_fail++; $display("FAIL zero_writes: got %0d want 0", acc_addr.size()); end
    n_cmp++; if (done_cyc !== pop_cyc + 2) begin n_fail++; $display("FAIL zero_done_time: got cycle %0d want %0d", done_cyc, pop_cyc + 2); end
    upd_q.delete(); drive_upd();
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] ea[40];
    int bad;
    clear_logs();
    rsp_hold = 1;
    for (int i = 0; i < 40; i++) begin
      push_rec(VW'(2 * i + 1), DW'(32'hB000_0000 + i));
      ea[i] = 64'h4000 + 64'((2 * i + 1) * 4);
    end
    give_token(40, 64'h4000);
    for (int k = 0; k < 80; k++) tick();
    #1;
    n_cmp++; if (acc_addr.size() !== MO) begin n_fail++; $display("FAIL bp_accepts: got %0d want %0d", acc_addr.size(), MO); end
    n_cmp++; if (upd_pops !== MO) begin n_fail++; $display("FAIL bp_pops: got %0d want %0d", upd_pops, MO); end
    n_cmp++; if (bus.upd_read !== 1'b0) begin n_fail++; $display("FAIL bp_upd_read: got %b want 0", bus.upd_read); end
    n_cmp++; if (dut.w_outst_cnt !== 5'd16) begin n_fail++; $display("FAIL bp_outst: got %0d want 16", dut.w_outst_cnt); end
    rsp_hold = 0;
    for (int k = 0; k < 400 && done_cnt == 0; k++) tick();
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    n_cmp++; if (rsp_cnt !== 40 || acc_addr.size() !== 40) begin n_fail++; $display("FAIL bp_total: got %0d rsp %0d writes want 40", rsp_cnt, acc_addr.size()); end
    bad = 0;
    for (int i = 0; i < 40 && i < acc_addr.size(); i++)
      if (acc_addr[i] !== ea[i] || acc_data[i] !== DW'(32'hB000_0000 + i)) bad++;
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL bp_contents: got %0d wrong writes want 0", bad); end
    n_cmp++; if (done_cyc !== last_rsp_cyc + 2) begin n_fail++; $display("FAIL bp_done_time: got cycle %0d want %0d", done_cyc, last_rsp_cyc + 2); end
  endtask

  task automatic test_random_ready();
    logic [AW-1:0] ea[100];
    logic [VW-1:0] vid;
    logic [AW-1:0] base;
    int bad;
    clear_logs();
    base = 64'hFFFF_FFFF_FFFF_FF00;
    for (int i = 0; i < 100; i++) begin
      vid = (i == 50) ? 32'hFFFF_FFFF : VW'(3 * i);
      push_rec(vid, DW'(32'hD000_0000 ^ i));
      ea[i] = base + ({32'h0, vid} << 2);
    end
    give_token(100, base);
    rdy_rand = 1;
    for (int k = 0; k < 2000 && done_cnt == 0; k++) tick();
    rdy_rand = 0;
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL rr_done: got %0d want 1", done_cnt); end
    n_cmp++; if (acc_addr.size() !== 100) begin n_fail++; $display("FAIL rr_count: got %0d want 100", acc_addr.size()); end
    bad = 0;
    for (int i = 0; i < 100 && i < acc_addr.size(); i++)
      if (acc_addr[i] !== ea[i] || acc_data[i] !== DW'(32'hD000_0000 ^ i)) bad++;
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rr_contents: got %0d wrong writes want 0", bad); end
    n_cmp++; if (acc_addr.size() > 50 && acc_addr[50] !== 64'h0000_0003_FFFF_FEFC) begin n_fail++; $display("FAIL rr_wrap: got %h want 00000003fffffefc", acc_addr[50]); end
    n_cmp++; if (stab_viol !== 0) begin n_fail++; $display("FAIL rr_stable: got %0d changes under stall want 0", stab_viol); end
  endtask

  task automatic test_same_cycle();
    clear_logs();
    rsp_hold = 1;
    for (int i = 0; i < 15; i++) push_rec(VW'(i), DW'(32'h500 + i));
    give_token(16, 64'h0);
    for (int k = 0; k < 100 && acc_addr.size() < 15; k++) tick();
    tick(); tick();
    n_cmp++; if (dut.w_outst_cnt !== 5'd15) begin n_fail++; $display("FAIL sc_pre_outst: got %0d want 15", dut.w_outst_cnt); end
    rdy_fixed = 1'b0; bus.wr_req_ready = 1'b0;
    push_rec(15, 32'h50F);
    tick(); tick();
    n_cmp++; if (bus.wr_req_valid !== 1'b1) begin n_fail++; $display("FAIL sc_valid_held: got %b want 1", bus.wr_req_valid); end
    rdy_fixed = 1'b1; bus.wr_req_ready = 1'b1; bus.wr_rsp_valid = 1'b1;
    void'(pend.pop_front());
    tick();
    #1;
    n_cmp++; if (dut.w_outst_cnt !== 5'd15) begin n_fail++; $display("FAIL sc_outst: got %0d want 15", dut.w_outst_cnt); end
    n_cmp++; if (err_rsp !== 1'b0) begin n_fail++; $display("FAIL sc_no_err: got %b want 0", err_rsp); end
    rsp_hold = 0;
    for (int k = 0; k < 200 && done_cnt == 0; k++) tick();
    n_cmp++; if (done_cnt !== 1 || acc_addr.size() !== 16) begin n_fail++; $display("FAIL sc_done: got %0d pulses %0d writes want 1/16", done_cnt, acc_addr.size()); end
    bus.wr_rsp_valid = 1'b1;
    tick();
    #1;
    n_cmp++; if (err_rsp !== 1'b1) begin n_fail++; $display("FAIL sc_err_set: got %b want 1", err_rsp); end
    n_cmp++; if (dut.w_outst_cnt !== 5'd0) begin n_fail++; $display("FAIL sc_stray_cnt: got %0d want 0", dut.w_outst_cnt); end
    for (int k = 0; k < 5; k++) tick();
    n_cmp++; if (err_rsp !== 1'b1) begin n_fail++; $display("FAIL sc_err_sticky: got %b want 1", err_rsp); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    pend.delete();
    rsp_hold = 1;
    for (int i = 0; i < 10; i++) push_rec(VW'(i), DW'(32'h600 + i));
    give_token(10, 64'h2000);
    for (int k = 0; k < 100 && acc_addr.size() < 5; k++) tick();
    n_cmp++; if (dut.w_outst_cnt !== 5'd5 || busy !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got outst %0d busy %b want 5/1", dut.w_outst_cnt, busy); end
    #2;
    bus.start_empty_n = 1'b1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({bus.start_read, bus.upd_read, bus.wr_req_valid} !== 3'b000) begin n_fail++; $display("FAIL rm_handshake: got %b want 000", {bus.start_read, bus.upd_read, bus.wr_req_valid}); end
    n_cmp++; if (bus.wr_req_addr !== '0 || bus.wr_req_data !== '0) begin n_fail++; $display("FAIL rm_req_regs: got %h/%h want 0/0", bus.wr_req_addr, bus.wr_req_data); end
    n_cmp++; if ({busy, done, err_rsp} !== 3'b000) begin n_fail++; $display("FAIL rm_status: got %b want 000", {busy, done, err_rsp}); end
    n_cmp++; if (dut.w_outst_cnt !== 5'd0) begin n_fail++; $display("FAIL rm_outst: got %0d want 0", dut.w_outst_cnt); end
    #2;
    prev_stall = 0;
    upd_q.delete(); pend.delete(); drive_upd();
    bus.start_empty_n = 1'b0; bus.wr_rsp_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    rsp_hold = 0;
    tick();
    bus.wr_rsp_valid = 1'b1;
    tick();
    #1;
    n_cmp++; if (err_rsp !== 1'b1 || dut.w_outst_cnt !== 5'd0) begin n_fail++; $display("FAIL rm_late_rsp: got err %b outst %0d want 1/0", err_rsp, dut.w_outst_cnt); end
    clear_logs();
    push_rec(1, 32'h61); push_rec(3, 32'h63);
    give_token(2, 64'h2000);
    for (int k = 0; k < 100 && done_cnt == 0; k++) tick();
    n_cmp++; if (done_cnt !== 1 || acc_addr.size() !== 2 || upd_pops !== 2) begin n_fail++; $display("FAIL rm_job: got %0d pulses %0d writes %0d pops want 1/2/2", done_cnt, acc_addr.size(), upd_pops); end
    n_cmp++; if (acc_addr.size() < 2 || acc_addr[0] !== 64'h2004 || acc_data[0] !== 32'h61 || acc_addr[1] !== 64'h200C || acc_data[1] !== 32'h63) begin
      n_fail++; $display("FAIL rm_writes: got %0d entries, first %h/%h want 2004/61 then 200c/63", acc_addr.size(),
                         (acc_addr.size() > 0) ? acc_addr[0] : 'x, (acc_data.size() > 0) ? acc_data[0] : 'x);
    end
    n_cmp++; if (dut.w_outst_cnt !== 5'd0) begin n_fail++; $display("FAIL rm_final_outst: got %0d want 0", dut.w_outst_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_random_ready();
    test_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
